// File: rtl/cpu_core.sv
// Multi-cycle accumulator-free CPU core: FETCH/DECODE/OPERAND/MEM/EXEC/HALT sequencer,
// 4-entry register file, Z/C flag ALU, conditional jumps, load/store and an output port.
module cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_MEM     = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                z_q, c_q;
  logic [DATA_W-1:0]   ir_q, opr_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q, halted_q;

  logic [3:0]          op;
  logic [1:0]          rd, rs;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W-1:0]   alu_res_d;
  logic                alu_c_d;
  logic                alu_op_d;
  logic                two_word_d;
  logic [ADDR_W-1:0]   exec_pc_d;

  assign op     = ir_q[7:4];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign pc_inc = pc_q + PC_ONE;
  assign target = opr_q[ADDR_W-1:0];

  // ALU result and carry/borrow; flags are committed only for ops 5-9
  always_comb begin
    alu_res_d = regs_q[rd];
    alu_c_d   = 1'b0;
    alu_op_d  = 1'b1;
    case (op)
      OP_ADD:  {alu_c_d, alu_res_d} = {1'b0, regs_q[rd]} + {1'b0, regs_q[rs]};
      OP_SUB:  {alu_c_d, alu_res_d} = {1'b0, regs_q[rd]} - {1'b0, regs_q[rs]};
      OP_AND:  alu_res_d = regs_q[rd] & regs_q[rs];
      OP_OR:   alu_res_d = regs_q[rd] | regs_q[rs];
      OP_XOR:  alu_res_d = regs_q[rd] ^ regs_q[rs];
      default: alu_op_d = 1'b0;
    endcase
  end

  // Instruction-length decode and jump resolution for the EXEC cycle
  always_comb begin
    two_word_d = 1'b0;
    exec_pc_d  = pc_q;
    case (op)
      OP_LDI, OP_LD, OP_ST: two_word_d = 1'b1;
      OP_JMP: begin
        two_word_d = 1'b1;
        exec_pc_d  = target;
      end
      OP_JZ: begin
        two_word_d = 1'b1;
        if (z_q) exec_pc_d = target;
        else     exec_pc_d = pc_q;
      end
      OP_JC: begin
        two_word_d = 1'b1;
        if (c_q) exec_pc_d = target;
        else     exec_pc_d = pc_q;
      end
      default: two_word_d = 1'b0;
    endcase
  end

  // Sequencer: every memory-facing output is registered and changes only with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= {ADDR_W{1'b0}};
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {DATA_W{1'b0}};
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ir_q        <= {DATA_W{1'b0}};
      opr_q       <= {DATA_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            ir_q      <= mem_rdata;
            pc_q      <= pc_inc;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (two_word_d) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            state_q    <= S_OPERAND;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_OPERAND: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            opr_q     <= mem_rdata;
            pc_q      <= pc_inc;
            mem_req_q <= 1'b0;
            if (op == OP_LD || op == OP_ST) state_q <= S_MEM;
            else                            state_q <= S_EXEC;
          end
        end
        // First MEM cycle launches the data transfer; the fetch follows straight after its ack
        S_MEM: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op == OP_ST);
            mem_addr_q  <= target;
            mem_wdata_q <= regs_q[rs];
          end else if (mem_ack) begin
            if (op == OP_LD) regs_q[rd] <= mem_rdata;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            state_q    <= S_FETCH;
          end
        end
        S_EXEC: begin
          case (op)
            OP_LDI: regs_q[rd] <= opr_q;
            OP_MOV: regs_q[rd] <= regs_q[rs];
            OP_OUT: begin
              out_data_q  <= regs_q[rs];
              out_valid_q <= 1'b1;
            end
            default: begin
              if (alu_op_d) begin
                regs_q[rd] <= alu_res_d;
                z_q        <= (alu_res_d == {DATA_W{1'b0}});
                c_q        <= alu_c_d;
              end
            end
          endcase
          if (op == OP_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            pc_q       <= exec_pc_d;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= exec_pc_d;
            state_q    <= S_FETCH;
          end
        end
        S_HALT: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          halted_q  <= 1'b1;
        end
        default: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: table of small programs run to HLT against a
// 256-byte memory model with programmable ack delay, plus reset/latency/wrap sequences.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_req, mem_we, mem_ack, out_valid, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data, pc;

  always #5 clk = ~clk;

  cpu_core #(.DATA_W(8), .ADDR_W(8), .NREGS(4)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_data(out_data), .out_valid(out_valid), .pc(pc), .halted(halted)
  );

  // memory model
  logic [7:0] mem [0:255];
  int         ack_delay = 0;
  int         wait_cnt = 0;
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  logic       clr = 1'b1;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  int         wr_n = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (clr) wr_n <= 0;
    else if (mem_req && mem_we && mem_ack) begin
      wr_n    <= wr_n + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  // bus/output monitor sampled away from the active edge
  int         pulses = 0, stab_err = 0, we_err = 0;
  logic [7:0] out_last = 8'h00;
  logic       pend = 1'b0, p_we = 1'b0;
  logic [7:0] p_addr = 8'h00, p_wdata = 8'h00;

  always @(negedge clk) begin
    if (clr) begin
      pulses   <= 0;
      stab_err <= 0;
      we_err   <= 0;
      out_last <= 8'h00;
      pend     <= 1'b0;
    end else if (reset) begin
      pend <= 1'b0;
    end else begin
      if (out_valid) begin
        pulses   <= pulses + 1;
        out_last <= out_data;
      end
      if (!mem_req && mem_we) we_err <= we_err + 1;
      if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we ||
                   (mem_we && mem_wdata != p_wdata)))
        stab_err <= stab_err + 1;
      pend    <= mem_req && !mem_ack;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
    end
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [127:0] p0;      // bytes at 0x00.., first byte in MSBs
    logic [7:0]   base1;
    logic [63:0]  p1;      // bytes at base1..
    int           delay;
    logic [7:0]   e_out;
    logic [7:0]   e_pc;
    int           e_pulses;
    int           e_wr_n;
    logic [7:0]   e_wr_addr;
    logic [7:0]   e_wr_data;
  } vec_t;

  vec_t vt [8];

  task automatic load_vec(input vec_t v);
    reset     = 1'b1;
    clr       = 1'b1;
    ack_delay = v.delay;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'hF0);
    for (int i = 0; i < 16; i++) poke(8'(i), v.p0[8*(15-i) +: 8]);
    for (int i = 0; i < 8; i++) poke(8'(v.base1 + 8'(i)), v.p1[8*(7-i) +: 8]);
    ld_en = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_halt(input int bound, input string nm);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halt"}, int'(halted), 1);
  endtask

  // cycles from start of a fetch at a0 to start of a fetch at a1
  task automatic cycles_between(input logic [7:0] a0, input logic [7:0] a1, output int cyc);
    int n;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == a0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_req && !mem_we && mem_addr == a1) && cyc < 200);
  endtask

  vec_t lt;
  int   cyc, reqs;

  initial begin
    reset = 1'b1;
    //           program @0x00                          base   program @base1        dly out    pc    pls wr addr   data
    vt[0] = '{128'h10C81464_51D0C010_F0F0F0F0_F0F0F0F0, 8'h10, 64'hB020F0F0_F0F0F0F0, 0, 8'h2C, 8'h13, 1, 0, 8'h00, 8'h00};
    vt[1] = '{128'h18051C05_6BB020F0_F0F0F0F0_F0F0F0F0, 8'h20, 64'hC030D2F0_F0F0F0F0, 0, 8'h00, 8'h24, 1, 0, 8'h00, 8'h00};
    vt[2] = '{128'h18051C06_6BB020C0_30F0F0F0_F0F0F0F0, 8'h30, 64'hD2F0F0F0_F0F0F0F0, 0, 8'hFF, 8'h32, 1, 0, 8'h00, 8'h00};
    vt[3] = '{128'h9F145A31_802080D0_B040F0F0_F0F0F0F0, 8'h40, 64'hF0F0F0F0_F0F0F0F0, 0, 8'h5A, 8'h41, 1, 1, 8'h80, 8'h5A};
    vt[4] = '{128'h14F04D18_3C7E8BD2_A050F0F0_F0F0F0F0, 8'h50, 64'h00E0D3F0_F0F0F0F0, 0, 8'h30, 8'h54, 2, 0, 8'h00, 8'h00};
    vt[5] = vt[3]; vt[5].delay = 3;
    vt[6] = vt[0]; vt[6].delay = 2;
    vt[7] = vt[4]; vt[7].delay = 1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", int'(mem_req), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_outv", int'(out_valid), 0);
    chk("rst_out", int'(out_data), 0);

    for (int i = 0; i < 8; i++) begin
      load_vec(vt[i]);
      reset = 1'b0;
      wait_halt(3000, $sformatf("v%0d", i));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_req_after_halt", i), int'(mem_req), 0);
      chk($sformatf("v%0d_out", i), int'(out_last), int'(vt[i].e_out));
      chk($sformatf("v%0d_pc", i), int'(pc), int'(vt[i].e_pc));
      chk($sformatf("v%0d_pulses", i), pulses, vt[i].e_pulses);
      chk($sformatf("v%0d_wr_n", i), wr_n, vt[i].e_wr_n);
      chk($sformatf("v%0d_stable", i), stab_err, 0);
      chk($sformatf("v%0d_we_idle", i), we_err, 0);
      if (vt[i].e_wr_n != 0) begin
        chk($sformatf("v%0d_wr_addr", i), int'(wr_addr), int'(vt[i].e_wr_addr));
        chk($sformatf("v%0d_wr_data", i), int'(wr_data), int'(vt[i].e_wr_data));
      end
    end

    // reset while a fetch is stalled
    load_vec(vt[4]);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    ack_delay = 100;
    repeat (3) @(negedge clk);
    chk("midrst_waiting", int'(mem_req && !mem_ack), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", int'(mem_req), 0);
    chk("midrst_pc", int'(pc), 0);
    chk("midrst_we", int'(mem_we), 0);
    reset     = 1'b0;
    ack_delay = 0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_first_req", int'(mem_req), 1);
    chk("midrst_first_addr", int'(mem_addr), 0);

    // latency: LD r0,[80]; NOP; ADD r0,r1; HLT
    lt = '{128'h20800051_F0F0F0F0_F0F0F0F0_F0F0F0F0, 8'h40, 64'hF0F0F0F0_F0F0F0F0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00};
    load_vec(lt);
    reset = 1'b0;
    cycles_between(8'h00, 8'h02, cyc); chk("lat_ld_0", cyc, 5);
    cycles_between(8'h02, 8'h03, cyc); chk("lat_nop_0", cyc, 3);
    cycles_between(8'h03, 8'h04, cyc); chk("lat_add_0", cyc, 3);
    lt.delay = 3;
    load_vec(lt);
    reset = 1'b0;
    cycles_between(8'h00, 8'h02, cyc); chk("lat_ld_3", cyc, 14);
    cycles_between(8'h02, 8'h03, cyc); chk("lat_nop_3", cyc, 6);
    wait_halt(200, "lat3");
    chk("lat3_stable", stab_err, 0);

    // pc wrap: JMP 0xFE; NOP @FE; NOP @FF; HLT @00 (patched in once past 0x00)
    lt = '{128'hA0FEF0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0, 8'hF8, 64'hF0F0F0F0_F0F00000, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00};
    load_vec(lt);
    reset = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_addr == 8'hFE) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_reach_fe", int'(mem_addr), 8'hFE);
    poke(8'h00, 8'hF0);
    ld_en = 1'b0;
    wait_halt(100, "wrap");
    chk("wrap_pc", int'(pc), 8'h01);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    chk("wrap_req_quiet", reqs, 0);
    chk("wrap_still_halted", int'(halted), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("wrap_reset_exit", int'(halted), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
